// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: default datapath widths, the
// highest legal ALU select code, and the response-slot state encoding.
package alu_arb_pkg;

    localparam int XLEN  = 32;
    localparam int SEL_W = 4;

    localparam logic [SEL_W-1:0] SEL_MAX = 4'b0111;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   eligible  - per-requester eligibility
//   prio      - current priority pointer (index favoured on a tie)
//   grant     - one-hot grant, or zero when nobody is eligible
//   prio_next - pointer value after this cycle's grant
module rr_arbiter2 (
    input  logic [1:0] eligible,
    input  logic       prio,
    output logic [1:0] grant,
    output logic       prio_next
);

    always_comb begin
        grant     = '0;
        prio_next = prio;
        unique case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
        // The pointer moves to whichever requester lost (or did not ask).
        if (grant[0]) begin
            prio_next = 1'b1;
        end else if (grant[1]) begin
            prio_next = 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters. Each cycle
// at most one eligible request is granted round-robin; its operands drive
// the ALU ports and the ALU result is captured into that requester's
// response slot on the same edge.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid/req_ready - per-requester request handshake (ready = grant)
//   req_opA/opB/sel     - per-requester operands and ALU select
//   rsp_valid/rsp_ready - per-requester response handshake
//   rsp_data/rsp_err    - captured result and illegal-select flag
//   alu_opA/opB/sel     - driven to the external ALU
//   alu_result          - returned from the external ALU
//   stall_cnt           - saturating count of cycles with an ungranted request
module alu_arbiter #(
    parameter int                 XLEN    = alu_arb_pkg::XLEN,
    parameter int                 SEL_W   = alu_arb_pkg::SEL_W,
    parameter logic [SEL_W-1:0]   SEL_MAX = alu_arb_pkg::SEL_MAX
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][XLEN-1:0]       req_opA,
    input  logic [1:0][XLEN-1:0]       req_opB,
    input  logic [1:0][SEL_W-1:0]      req_sel,
    output logic [1:0]                 rsp_valid,
    input  logic [1:0]                 rsp_ready,
    output logic [1:0][XLEN-1:0]       rsp_data,
    output logic [1:0]                 rsp_err,
    output logic [XLEN-1:0]            alu_opA,
    output logic [XLEN-1:0]            alu_opB,
    output logic [SEL_W-1:0]           alu_sel,
    input  logic [XLEN-1:0]            alu_result,
    output logic [15:0]                stall_cnt
);

    import alu_arb_pkg::*;

    logic        prio_q;
    logic        prio_next;
    logic [1:0]  slot_free;
    logic [1:0]  eligible;
    logic [1:0]  grant;
    logic [15:0] stall_q;

    // A slot can accept a new result if it is empty or being drained now.
    assign eligible = req_valid & slot_free;

    rr_arbiter2 u_rr (
        .eligible  (eligible),
        .prio      (prio_q),
        .grant     (grant),
        .prio_next (prio_next)
    );

    // The combinational outputs are forced low while reset is asserted so
    // every port reads zero during reset; the flops are already held then,
    // so the internal grant needs no such gating.
    assign req_ready = rst_n ? grant : '0;

    always_comb begin
        alu_opA = '0;
        alu_opB = '0;
        alu_sel = '0;
        if (req_ready[0]) begin
            alu_opA = req_opA[0];
            alu_opB = req_opB[0];
            alu_sel = req_sel[0];
        end else if (req_ready[1]) begin
            alu_opA = req_opA[1];
            alu_opB = req_opB[1];
            alu_sel = req_sel[1];
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_slot
        slot_state_e    state_q;
        slot_state_e    state_d;
        logic [XLEN-1:0] data_q;
        logic            err_q;

        assign slot_free[i] = (state_q == SLOT_EMPTY) || rsp_ready[i];
        assign rsp_valid[i] = (state_q == SLOT_FULL);
        assign rsp_data[i]  = data_q;
        assign rsp_err[i]   = err_q;

        always_comb begin
            state_d = state_q;
            unique case (state_q)
                SLOT_EMPTY: if (grant[i]) state_d = SLOT_FULL;
                SLOT_FULL:  if (!grant[i] && rsp_ready[i]) state_d = SLOT_EMPTY;
                default:    state_d = SLOT_EMPTY;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= SLOT_EMPTY;
                data_q  <= '0;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                if (grant[i]) begin
                    data_q <= alu_result;
                    err_q  <= (req_sel[i] > SEL_MAX);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            prio_q <= prio_next;
            if (|(req_valid & ~grant) && (stall_q != '1)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_opA = '0;
    logic [1:0][31:0] req_opB = '0;
    logic [1:0][3:0]  req_sel = '0;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready = '0;
    logic [1:0][31:0] rsp_data;
    logic [1:0]       rsp_err;
    logic [31:0]      alu_opA;
    logic [31:0]      alu_opB;
    logic [3:0]       alu_sel;
    logic [31:0]      alu_result;
    logic [15:0]      stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(32), .SEL_W(4), .SEL_MAX(4'b0111)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opA    (req_opA),
        .req_opB    (req_opB),
        .req_sel    (req_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .alu_opA    (alu_opA),
        .alu_opB    (alu_opB),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .stall_cnt  (stall_cnt)
    );

    // Bench ALU: add, sub, anything else xor.
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] s);
        case (s)
            4'b0000: return a + b;
            4'b0001: return a - b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb alu_result = alu_ref(alu_opA, alu_opB, alu_sel);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at a negedge with reset released.
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        pre_rst;
        logic [1:0]  vld;
        logic [1:0]  rdy;
        logic [31:0] a0, b0, a1, b1;
        logic [3:0]  s0, s1;
        logic [1:0]  gnt;
        logic [1:0]  rv;
        logic [1:0]  err;
        logic [31:0] d0, d1;
        logic [15:0] stall;
    } vec_t;

    function automatic vec_t mk(input logic p, input logic [1:0] vld, input logic [1:0] rdy,
                                input int a0, input int b0, input logic [3:0] s0,
                                input int a1, input int b1, input logic [3:0] s1,
                                input logic [1:0] gnt, input logic [1:0] rv, input logic [1:0] err,
                                input int d0, input int d1, input int stall);
        vec_t v;
        v.pre_rst = p;   v.vld = vld; v.rdy = rdy;
        v.a0 = 32'(a0);  v.b0 = 32'(b0); v.s0 = s0;
        v.a1 = 32'(a1);  v.b1 = 32'(b1); v.s1 = s1;
        v.gnt = gnt;     v.rv = rv;   v.err = err;
        v.d0 = 32'(d0);  v.d1 = 32'(d1); v.stall = 16'(stall);
        return v;
    endfunction

    vec_t tbl[$];

    // Reference model state for the random phase.
    logic        m_prio;
    logic [1:0]  m_full;
    logic [31:0] m_data [2];
    logic [1:0]  m_err;
    int          m_stall;

    initial begin
        logic [1:0]  ex_gnt;
        logic [31:0] ex_a, ex_b;
        logic [3:0]  ex_s;
        logic [1:0]  elig;
        int          g;

        //          pre vld    rdy    a0 b0 s0     a1 b1 s1     gnt    rv     err    d0  d1  stall
        tbl.push_back(mk(1, 2'b01, 2'b01, 5, 1, 4'd0, 0, 0, 4'd0, 2'b01, 2'b01, 2'b00, 6,  0,  0));
        tbl.push_back(mk(1, 2'b11, 2'b11, 10,3, 4'd0, 20,8, 4'd1, 2'b01, 2'b01, 2'b00, 13, 0,  1));
        tbl.push_back(mk(0, 2'b11, 2'b11, 10,3, 4'd0, 20,8, 4'd1, 2'b10, 2'b10, 2'b00, 13, 12, 2));
        tbl.push_back(mk(0, 2'b11, 2'b11, 10,3, 4'd0, 20,8, 4'd1, 2'b01, 2'b01, 2'b00, 13, 12, 3));
        tbl.push_back(mk(0, 2'b11, 2'b11, 10,3, 4'd0, 20,8, 4'd1, 2'b10, 2'b10, 2'b00, 13, 12, 4));
        tbl.push_back(mk(1, 2'b10, 2'b00, 0, 0, 4'd0, 7, 4, 4'd1, 2'b10, 2'b10, 2'b00, 0,  3,  0));
        tbl.push_back(mk(0, 2'b10, 2'b00, 0, 0, 4'd0, 9, 1, 4'd0, 2'b00, 2'b10, 2'b00, 0,  3,  1));
        tbl.push_back(mk(0, 2'b10, 2'b00, 0, 0, 4'd0, 9, 1, 4'd0, 2'b00, 2'b10, 2'b00, 0,  3,  2));
        tbl.push_back(mk(0, 2'b10, 2'b10, 0, 0, 4'd0, 9, 1, 4'd0, 2'b10, 2'b10, 2'b00, 0,  10, 2));
        tbl.push_back(mk(0, 2'b00, 2'b10, 0, 0, 4'd0, 9, 1, 4'd0, 2'b00, 2'b00, 2'b00, 0,  10, 2));
        tbl.push_back(mk(0, 2'b01, 2'b00, 3, 2, 4'd8, 0, 0, 4'd0, 2'b01, 2'b01, 2'b01, 1,  10, 2));
        tbl.push_back(mk(0, 2'b01, 2'b01, 4, 4, 4'd0, 0, 0, 4'd0, 2'b01, 2'b01, 2'b00, 8,  10, 2));
        tbl.push_back(mk(0, 2'b10, 2'b00, 0, 0, 4'd0, 6, 6, 4'd0, 2'b10, 2'b11, 2'b00, 8,  12, 2));

        @(negedge clk);
        do_reset();
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_stall", 64'(stall_cnt), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);

        foreach (tbl[k]) begin
            if (tbl[k].pre_rst) do_reset();
            req_valid  = tbl[k].vld;
            rsp_ready  = tbl[k].rdy;
            req_opA[0] = tbl[k].a0; req_opB[0] = tbl[k].b0; req_sel[0] = tbl[k].s0;
            req_opA[1] = tbl[k].a1; req_opB[1] = tbl[k].b1; req_sel[1] = tbl[k].s1;
            ex_a = '0; ex_b = '0; ex_s = '0;
            if (tbl[k].gnt == 2'b01) begin
                ex_a = tbl[k].a0; ex_b = tbl[k].b0; ex_s = tbl[k].s0;
            end else if (tbl[k].gnt == 2'b10) begin
                ex_a = tbl[k].a1; ex_b = tbl[k].b1; ex_s = tbl[k].s1;
            end
            #1;
            chk($sformatf("tbl%0d_req_ready", k), 64'(req_ready), 64'(tbl[k].gnt));
            chk($sformatf("tbl%0d_alu_opA", k), 64'(alu_opA), 64'(ex_a));
            chk($sformatf("tbl%0d_alu_opB", k), 64'(alu_opB), 64'(ex_b));
            chk($sformatf("tbl%0d_alu_sel", k), 64'(alu_sel), 64'(ex_s));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_rsp_valid", k), 64'(rsp_valid), 64'(tbl[k].rv));
            chk($sformatf("tbl%0d_rsp_err", k), 64'(rsp_err), 64'(tbl[k].err));
            chk($sformatf("tbl%0d_rsp_data0", k), 64'(rsp_data[0]), 64'(tbl[k].d0));
            chk($sformatf("tbl%0d_rsp_data1", k), 64'(rsp_data[1]), 64'(tbl[k].d1));
            chk($sformatf("tbl%0d_stall", k), 64'(stall_cnt), 64'(tbl[k].stall));
            @(negedge clk);
        end

        // Asynchronous reset with both slots full.
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        #1;
        chk("full_block_ready", 64'(req_ready), 64'd0);
        chk("full_both_valid", 64'(rsp_valid), 64'd3);
        #1;
        rst_n     = 1'b0;
        rsp_ready = 2'b11;
        #1;
        chk("arst_req_ready", 64'(req_ready), 64'd0);
        chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("arst_rsp_data0", 64'(rsp_data[0]), 64'd0);
        chk("arst_rsp_data1", 64'(rsp_data[1]), 64'd0);
        chk("arst_rsp_err", 64'(rsp_err), 64'd0);
        chk("arst_alu_opA", 64'(alu_opA), 64'd0);
        chk("arst_alu_opB", 64'(alu_opB), 64'd0);
        chk("arst_alu_sel", 64'(alu_sel), 64'd0);
        chk("arst_stall", 64'(stall_cnt), 64'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        rsp_ready  = 2'b00;
        req_opA[0] = 32'h1234; req_opB[0] = 32'd1; req_sel[0] = 4'd0;
        #1;
        chk("post_rst_prio_grant", 64'(req_ready), 64'd1);
        chk("post_rst_alu_opA", 64'(alu_opA), 64'h1234);
        @(posedge clk);
        #1;
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("post_rst_rsp_data0", 64'(rsp_data[0]), 64'h1235);
        @(negedge clk);

        // Saturation: requester 0 held against its own full slot.
        do_reset();
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        repeat (1000) @(negedge clk);
        #1;
        chk("stall_mid", 64'(stall_cnt), 64'd999);
        @(negedge clk);
        repeat (69000) @(negedge clk);
        #1;
        chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
        chk("stall_sat_blocked", 64'(req_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("stall_sat_hold", 64'(stall_cnt), 64'hFFFF);
        @(negedge clk);

        // Random traffic against the reference model.
        do_reset();
        m_prio = 1'b0; m_full = '0; m_err = '0; m_stall = 0;
        m_data[0] = '0; m_data[1] = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            req_valid = 2'($urandom_range(0, 3));
            rsp_ready = 2'($urandom_range(0, 3));
            for (int r = 0; r < 2; r++) begin
                req_opA[r] = $urandom();
                req_opB[r] = $urandom();
                req_sel[r] = 4'($urandom_range(0, 9));
            end
            #1;
            elig[0] = req_valid[0] && (!m_full[0] || rsp_ready[0]);
            elig[1] = req_valid[1] && (!m_full[1] || rsp_ready[1]);
            if (elig == 2'b00)      g = -1;
            else if (elig == 2'b11) g = int'(m_prio);
            else                    g = elig[0] ? 0 : 1;
            ex_gnt = (g < 0) ? 2'b00 : 2'(1 << g);
            ex_a = (g < 0) ? 32'd0 : req_opA[g];
            ex_b = (g < 0) ? 32'd0 : req_opB[g];
            ex_s = (g < 0) ? 4'd0  : req_sel[g];
            chk("rnd_req_ready", 64'(req_ready), 64'(ex_gnt));
            chk("rnd_alu_opA", 64'(alu_opA), 64'(ex_a));
            chk("rnd_alu_opB", 64'(alu_opB), 64'(ex_b));
            chk("rnd_alu_sel", 64'(alu_sel), 64'(ex_s));
            chk("rnd_rsp_valid", 64'(rsp_valid), 64'(m_full));
            chk("rnd_rsp_data0", 64'(rsp_data[0]), 64'(m_data[0]));
            chk("rnd_rsp_data1", 64'(rsp_data[1]), 64'(m_data[1]));
            chk("rnd_rsp_err", 64'(rsp_err), 64'(m_err));
            chk("rnd_stall", 64'(stall_cnt), 64'(m_stall));
            @(posedge clk);
            for (int r = 0; r < 2; r++) begin
                if (r == g) begin
                    m_full[r] = 1'b1;
                    m_data[r] = alu_ref(req_opA[r], req_opB[r], req_sel[r]);
                    m_err[r]  = (req_sel[r] > 4'd7);
                end else if (rsp_ready[r]) begin
                    m_full[r] = 1'b0;
                end
            end
            if (g >= 0) m_prio = (g == 0);
            if (((req_valid & ~ex_gnt) != 2'b00) && m_stall < 65535) m_stall++;
            @(negedge clk);
        end
        #1;
        chk("rnd_final_rsp_valid", 64'(rsp_valid), 64'(m_full));
        chk("rnd_final_stall", 64'(stall_cnt), 64'(m_stall));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
